awb_gain_est: RTL

- Gray-world auto-white-balance estimator. It is the producer of the per-channel gains consumed by the white-balance stage.
- Watches the same Bayer pixel stream the WB stage sees: value, color and frame-last marker.
- Accumulates per-channel sums and counts over one frame, then computes red and blue gains relative to green with a sequential divider.
- Publishes K_R/K_G/K_B plus a gain-valid flag, which connect directly to the WB stage's gain inputs.

---
 rtl/awb_gain_est.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/awb_gain_est.sv
// Gray-world auto-white-balance estimator: accumulates per-channel Bayer sums/counts
// over a frame, then derives Q8.8 red/blue gains relative to green with a serial divider.
module awb_gain_est #(
    parameter int CNT_W = 20,
    parameter int SUM_W = 28
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_value_i,
    input  logic [1:0]  color_i,
    input  logic [7:0]  value_i,
    input  logic        last_i,
    output logic [15:0] K_R,
    output logic [15:0] K_G,
    output logic [15:0] K_B,
    output logic        valid_gain_o,
    output logic        busy_o
);

    localparam int P_W = SUM_W + CNT_W;
    localparam logic [15:0] UNITY = 16'h0100;
    localparam logic [15:0] GAIN_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_ACCUM,
        ST_MUL,
        ST_DIV_R,
        ST_DIV_B,
        ST_PUB
    } state_t;

    state_t state_q, state_d;

    logic [SUM_W-1:0] s_r_q, s_r_d, s_g_q, s_g_d, s_b_q, s_b_d;
    logic [CNT_W-1:0] c_r_q, c_r_d, c_g_q, c_g_d, c_b_q, c_b_d;
    logic [P_W-1:0]   nr_q, nr_d, dr_q, dr_d, nb_q, nb_d, db_q, db_d;
    logic [P_W-1:0]   rem_q, rem_d;
    logic [15:0]      dsh_q, dsh_d;
    logic [14:0]      quo_q, quo_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [15:0]      kr_new_q, kr_new_d, kb_new_q, kb_new_d;
    logic [15:0]      kr_q, kr_d, kb_q, kb_d;
    logic             vld_q, vld_d;

    // Saturation check: quotient NR*256/DR would not fit in 16 bits.
    function automatic logic div_ovf(input logic [P_W-1:0] n, input logic [P_W-1:0] d);
        return {8'h00, n} >= {d, 8'h00};
    endfunction

    function automatic logic [15:0] gain_sel(input logic unity, input logic sat,
                                             input logic [15:0] quo);
        if (unity)
            return UNITY;
        else if (sat)
            return GAIN_MAX;
        else
            return quo;
    endfunction

    logic             sel_b, first_step, ge, unity_cur, sat_cur;
    logic [P_W-1:0]   n_sel, d_sel, rem_cur, rem_nx;
    logic [15:0]      dsh_cur, quo_res;
    logic [14:0]      quo_cur;
    logic [P_W:0]     rem_sh;
    logic [SUM_W-1:0] value_ext;

    assign value_ext = {{(SUM_W-8){1'b0}}, value_i};

    // The first divider cycle seeds itself straight from the registered products.
    assign sel_b      = (state_q == ST_DIV_B);
    assign n_sel      = sel_b ? nb_q : nr_q;
    assign d_sel      = sel_b ? db_q : dr_q;
    assign first_step = (bit_cnt_q == 4'd0);
    assign rem_cur    = first_step ? (n_sel >> 8) : rem_q;
    assign dsh_cur    = first_step ? {n_sel[7:0], 8'h00} : dsh_q;
    assign quo_cur    = first_step ? 15'd0 : quo_q;
    assign rem_sh     = {rem_cur, dsh_cur[15]};
    assign ge         = (rem_sh >= {1'b0, d_sel});
    assign rem_nx     = ge ? (rem_sh[P_W-1:0] - d_sel) : rem_sh[P_W-1:0];
    assign quo_res    = {quo_cur, ge};
    assign unity_cur  = sel_b ? ((c_b_q == '0) || (c_g_q == '0))
                              : ((c_r_q == '0) || (c_g_q == '0));
    assign sat_cur    = div_ovf(n_sel, d_sel);

    always_comb begin
        state_d   = state_q;
        s_r_d     = s_r_q;
        s_g_d     = s_g_q;
        s_b_d     = s_b_q;
        c_r_d     = c_r_q;
        c_g_d     = c_g_q;
        c_b_d     = c_b_q;
        nr_d      = nr_q;
        dr_d      = dr_q;
        nb_d      = nb_q;
        db_d      = db_q;
        rem_d     = rem_q;
        dsh_d     = dsh_q;
        quo_d     = quo_q;
        bit_cnt_d = bit_cnt_q;
        kr_new_d  = kr_new_q;
        kb_new_d  = kb_new_q;
        kr_d      = kr_q;
        kb_d      = kb_q;
        vld_d     = vld_q;

        case (state_q)
            ST_ACCUM: begin
                if (valid_value_i) begin
                    case (color_i)
                        2'd0: begin
                            s_r_d = s_r_q + value_ext;
                            c_r_d = c_r_q + CNT_W'(1);
                        end
                        2'd1: begin
                            s_g_d = s_g_q + value_ext;
                            c_g_d = c_g_q + CNT_W'(1);
                        end
                        2'd2: begin
                            s_b_d = s_b_q + value_ext;
                            c_b_d = c_b_q + CNT_W'(1);
                        end
                        default: ;
                    endcase
                    if (last_i)
                        state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                // Cross-multiplied so the gain is (S_G/C_G)/(S_c/C_c) without a mean divide.
                nr_d      = P_W'(s_g_q) * P_W'(c_r_q);
                dr_d      = P_W'(s_r_q) * P_W'(c_g_q);
                nb_d      = P_W'(s_g_q) * P_W'(c_b_q);
                db_d      = P_W'(s_b_q) * P_W'(c_g_q);
                bit_cnt_d = 4'd0;
                state_d   = ST_DIV_R;
            end
            ST_DIV_R, ST_DIV_B: begin
                rem_d     = rem_nx;
                dsh_d     = {dsh_cur[14:0], 1'b0};
                quo_d     = quo_res[14:0];
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd15) begin
                    if (sel_b) begin
                        kb_new_d = gain_sel(unity_cur, sat_cur, quo_res);
                        state_d  = ST_PUB;
                    end else begin
                        kr_new_d = gain_sel(unity_cur, sat_cur, quo_res);
                        state_d  = ST_DIV_B;
                    end
                end
            end
            ST_PUB: begin
                kr_d    = kr_new_q;
                kb_d    = kb_new_q;
                vld_d   = 1'b1;
                s_r_d   = '0;
                s_g_d   = '0;
                s_b_d   = '0;
                c_r_d   = '0;
                c_g_d   = '0;
                c_b_d   = '0;
                state_d = ST_ACCUM;
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ACCUM;
            s_r_q     <= '0;
            s_g_q     <= '0;
            s_b_q     <= '0;
            c_r_q     <= '0;
            c_g_q     <= '0;
            c_b_q     <= '0;
            nr_q      <= '0;
            dr_q      <= '0;
            nb_q      <= '0;
            db_q      <= '0;
            rem_q     <= '0;
            dsh_q     <= '0;
            quo_q     <= '0;
            bit_cnt_q <= '0;
            kr_new_q  <= UNITY;
            kb_new_q  <= UNITY;
            kr_q      <= UNITY;
            kb_q      <= UNITY;
            vld_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_r_q     <= s_r_d;
            s_g_q     <= s_g_d;
            s_b_q     <= s_b_d;
            c_r_q     <= c_r_d;
            c_g_q     <= c_g_d;
            c_b_q     <= c_b_d;
            nr_q      <= nr_d;
            dr_q      <= dr_d;
            nb_q      <= nb_d;
            db_q      <= db_d;
            rem_q     <= rem_d;
            dsh_q     <= dsh_d;
            quo_q     <= quo_d;
            bit_cnt_q <= bit_cnt_d;
            kr_new_q  <= kr_new_d;
            kb_new_q  <= kb_new_d;
            kr_q      <= kr_d;
            kb_q      <= kb_d;
            vld_q     <= vld_d;
        end
    end

    assign K_R          = kr_q;
    assign K_G          = UNITY;
    assign K_B          = kb_q;
    assign valid_gain_o = vld_q;
    assign busy_o       = (state_q != ST_ACCUM);

endmodule
